mem_arbiter_rr: RTL and testbench

Parametrised memory arbiter between CPUS cores (instruction and data ports each) and the single-ported RAM. Replaces the per-cycle toggling arbiter: a grant is registered and held for the full RAM access. Data requests win over instruction requests, bounded by an instruction-fairness limit. Round-robin selection runs per request class. Sits between the per-core cache controllers and the RAM model, below coherence/bus control.

---
 rtl/mem_arbiter_rr.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Purpose: grants the single-ported RAM to one core's data or instruction port at a time; data wins, instruction fairness bounded.
// Latency: a request seen in IDLE drives the RAM enables one cycle later; each completed access is followed by one IDLE cycle.
// Backpressure: the owner sees wait=1 until the RAM reports ACCESS; every other port sees wait=1 and load=0.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   iREN/iaddr -> iwait/iload    per-core instruction read ports (core i at slice i)
//   dREN/dWEN/daddr/dstore ->
//     dwait/dload                per-core data read/write ports
//   ramREN/ramWEN/ramaddr/
//     ramstore <- ramload,ramstate  shared RAM port (ramstate: FREE/BUSY/ACCESS/ERROR)
module mem_arbiter_rr #(
    parameter int CPUS        = 2,
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DATA_STREAK = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS*WORD_W-1:0]   iload,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;

    localparam logic [1:0] RAM_FREE   = 2'b00;
    localparam logic [1:0] RAM_BUSY   = 2'b01;
    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_INSTR} state_e;

    state_e          fsm_q, fsm_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   dptr_q, dptr_d;
    logic [OW-1:0]   iptr_q, iptr_d;
    logic [3:0]      streak_q, streak_d;
    logic [CPUS-1:0] dreq;

    assign dreq = dREN | dWEN;

    // Round-robin scan starting just after 'last'. Walking from the farthest
    // candidate back to the nearest lets the nearest requester overwrite.
    function automatic logic [OW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                              input logic [OW-1:0]   last);
        logic [OW-1:0] pick;
        int            idx;
        pick = last;
        for (int k = CPUS; k >= 1; k--) begin
            idx = (int'(last) + k) % CPUS;
            if (req[idx[OW-1:0]]) pick = idx[OW-1:0];
        end
        return pick;
    endfunction

    always_comb begin
        fsm_d    = fsm_q;
        owner_d  = owner_q;
        dptr_d   = dptr_q;
        iptr_d   = iptr_q;
        streak_d = streak_q;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        // While reset is asserted the outputs stay at their idle values even
        // if a grant is still registered; the access is simply abandoned.
        if (!RST) begin
            case (fsm_q)
                S_IDLE: begin
                    // Data preempts instruction fetch until the streak limit
                    // is reached with a fetch still waiting.
                    if (|dreq && (streak_q < 4'(DATA_STREAK) || !(|iREN))) begin
                        fsm_d   = S_DATA;
                        owner_d = rr_pick(dreq, dptr_q);
                    end else if (|iREN) begin
                        fsm_d   = S_INSTR;
                        owner_d = rr_pick(iREN, iptr_q);
                    end
                end
                S_DATA: begin
                    if (!dreq[owner_q]) begin
                        // Owner withdrew: drop the grant, keep fairness state.
                        fsm_d = S_IDLE;
                    end else begin
                        ramaddr  = daddr[owner_q*ADDR_W +: ADDR_W];
                        ramWEN   = dWEN[owner_q];
                        ramREN   = dREN[owner_q] & ~dWEN[owner_q];
                        ramstore = dstore[owner_q*WORD_W +: WORD_W];
                        dload[owner_q*WORD_W +: WORD_W] = ramload;
                        dwait[owner_q] = (ramstate != RAM_ACCESS);
                        if (ramstate == RAM_ACCESS) begin
                            fsm_d    = S_IDLE;
                            dptr_d   = owner_q;
                            streak_d = (streak_q < 4'(DATA_STREAK)) ? streak_q + 4'd1
                                                                    : 4'(DATA_STREAK);
                        end
                    end
                end
                S_INSTR: begin
                    if (!iREN[owner_q]) begin
                        fsm_d = S_IDLE;
                    end else begin
                        ramaddr = iaddr[owner_q*ADDR_W +: ADDR_W];
                        ramREN  = 1'b1;
                        iload[owner_q*WORD_W +: WORD_W] = ramload;
                        iwait[owner_q] = (ramstate != RAM_ACCESS);
                        if (ramstate == RAM_ACCESS) begin
                            fsm_d    = S_IDLE;
                            iptr_d   = owner_q;
                            streak_d = 4'd0;
                        end
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q    <= S_IDLE;
            owner_q  <= '0;
            dptr_q   <= OW'(CPUS - 1);
            iptr_q   <= OW'(CPUS - 1);
            streak_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            owner_q  <= owner_d;
            dptr_q   <= dptr_d;
            iptr_q   <= iptr_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

    localparam int CPUS   = 2;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int DS     = 4;

    localparam logic [1:0] R_FREE   = 2'b00;
    localparam logic [1:0] R_BUSY   = 2'b01;
    localparam logic [1:0] R_ACCESS = 2'b10;
    localparam logic [1:0] R_ERROR  = 2'b11;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [CPUS-1:0]        iREN;
    logic [CPUS*ADDR_W-1:0] iaddr;
    logic [CPUS-1:0]        iwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*ADDR_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] dload;
    logic                   ramREN;
    logic                   ramWEN;
    logic [ADDR_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;

    mem_arbiter_rr #(.CPUS(CPUS), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .DATA_STREAK(DS)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial forever #5 CLK = ~CLK;

    // ---------------- stimulus state ----------------
    logic              rst_v   = 1'b1;
    logic [CPUS-1:0]   dren_v  = '0;
    logic [CPUS-1:0]   dwen_v  = '0;
    logic [CPUS-1:0]   iren_v  = '0;
    logic [ADDR_W-1:0] daddr_v  [CPUS];
    logic [ADDR_W-1:0] iaddr_v  [CPUS];
    logic [WORD_W-1:0] dstore_v [CPUS];
    int                mode     = 0;      // 0 directed, 1 random
    logic              auto_clr = 1'b1;   // drop a request after its completion
    int                acc_lat  = 1;      // grant cycle on which RAM answers ACCESS
    logic [1:0]        rs_wait  = R_BUSY; // ramstate otherwise
    logic [WORD_W-1:0] load_v   = '0;

    // ---------------- reference model (transaction level) ----------------
    logic            m_busy   = 1'b0;
    int              m_cls    = 0;        // 0 data, 1 instruction
    int              m_owner  = 0;
    int              m_dptr   = CPUS - 1;
    int              m_iptr   = CPUS - 1;
    int              m_streak = 0;
    int              m_gcnt   = 0;
    logic [CPUS-1:0] done_d   = '0;
    logic [CPUS-1:0] done_i   = '0;

    typedef struct {int cls; int core; logic [WORD_W-1:0] load;} cmp_t;
    typedef struct {logic ren; logic wen; logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] store;} cmd_t;
    typedef struct {int cls; int core; logic wen; logic [WORD_W-1:0] store;} log_t;

    cmp_t exp_cmp[$];
    cmd_t exp_cmd[$];
    log_t comp_log[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int rr_next(input logic [CPUS-1:0] req, input int last);
        for (int k = 1; k <= CPUS; k++)
            if (req[(last + k) % CPUS]) return (last + k) % CPUS;
        return -1;
    endfunction

    task automatic drive_inputs();
        RST = rst_v;
        dREN = dren_v;
        dWEN = dwen_v;
        iREN = iren_v;
        for (int c = 0; c < CPUS; c++) begin
            daddr[c*ADDR_W +: ADDR_W]  = daddr_v[c];
            iaddr[c*ADDR_W +: ADDR_W]  = iaddr_v[c];
            dstore[c*WORD_W +: WORD_W] = dstore_v[c];
        end
    endtask

    task automatic model_step();
        logic [CPUS-1:0] dreq;
        logic            held;
        cmd_t            cmd;
        cmp_t            cmp;
        dreq   = dren_v | dwen_v;
        done_d = '0;
        done_i = '0;
        if (rst_v) begin
            m_busy = 1'b0; m_owner = 0; m_dptr = CPUS - 1; m_iptr = CPUS - 1;
            m_streak = 0; m_gcnt = 0;
        end else if (!m_busy) begin
            if (|dreq && (m_streak < DS || !(|iren_v))) begin
                m_cls = 0; m_owner = rr_next(dreq, m_dptr); m_busy = 1'b1; m_gcnt = 1;
            end else if (|iren_v) begin
                m_cls = 1; m_owner = rr_next(iren_v, m_iptr); m_busy = 1'b1; m_gcnt = 1;
            end
        end else begin
            held = (m_cls == 0) ? dreq[m_owner] : iren_v[m_owner];
            if (!held) begin
                m_busy = 1'b0;
            end else begin
                if (m_cls == 0) begin
                    cmd.wen = dwen_v[m_owner];
                    cmd.ren = dren_v[m_owner] & ~dwen_v[m_owner];
                    cmd.addr = daddr_v[m_owner];
                    cmd.store = dstore_v[m_owner];
                end else begin
                    cmd.wen = 1'b0; cmd.ren = 1'b1;
                    cmd.addr = iaddr_v[m_owner]; cmd.store = '0;
                end
                exp_cmd.push_back(cmd);
                if (ramstate == R_ACCESS) begin
                    cmp.cls = m_cls; cmp.core = m_owner; cmp.load = ramload;
                    exp_cmp.push_back(cmp);
                    if (m_cls == 0) begin
                        m_dptr = m_owner;
                        m_streak = (m_streak + 1 > DS) ? DS : m_streak + 1;
                        done_d[m_owner] = 1'b1;
                    end else begin
                        m_iptr = m_owner;
                        m_streak = 0;
                        done_i[m_owner] = 1'b1;
                    end
                    m_busy = 1'b0;
                end else begin
                    m_gcnt++;
                end
            end
        end
    endtask

    task automatic rand_agents();
        for (int c = 0; c < CPUS; c++) begin
            if (!(dren_v[c] | dwen_v[c])) begin
                if ($urandom % 4 == 0) begin
                    dwen_v[c]   = 1'($urandom % 2);
                    dren_v[c]   = dwen_v[c] ? 1'($urandom % 2) : 1'b1;
                    daddr_v[c]  = $urandom;
                    dstore_v[c] = $urandom;
                end
            end else if ($urandom % 40 == 0) begin
                dren_v[c] = 1'b0; dwen_v[c] = 1'b0;
            end
            if (!iren_v[c]) begin
                if ($urandom % 4 == 0) begin
                    iren_v[c]  = 1'b1;
                    iaddr_v[c] = $urandom;
                end
            end else if ($urandom % 40 == 0) begin
                iren_v[c] = 1'b0;
            end
        end
    endtask

    // ---------------- driver: inputs, RAM behaviour, model ----------------
    initial begin
        for (int c = 0; c < CPUS; c++) begin
            daddr_v[c] = '0; iaddr_v[c] = '0; dstore_v[c] = '0;
        end
        drive_inputs();
        ramstate = R_FREE;
        ramload  = '0;
        forever begin
            int r;
            @(posedge CLK);
            #2;
            if (auto_clr) begin
                dren_v &= ~done_d;
                dwen_v &= ~done_d;
                iren_v &= ~done_i;
            end
            if (mode == 1) rand_agents();
            drive_inputs();
            if (mode == 1) begin
                r = int'($urandom % 100);
                if (m_busy)
                    ramstate = (r < 40) ? R_ACCESS : (r < 70) ? R_BUSY : (r < 85) ? R_ERROR : R_FREE;
                else
                    ramstate = 2'($urandom % 4);
                ramload = $urandom;
            end else begin
                ramstate = (m_busy && m_gcnt == acc_lat) ? R_ACCESS : rs_wait;
                ramload  = load_v;
            end
            #1;
            model_step();
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check_comp(input int cls, input int core, input logic [WORD_W-1:0] load);
        cmp_t e;
        log_t l;
        if (exp_cmp.size() == 0) begin
            chk("unexpected_completion", {8'(cls), 8'(core)}, 64'hFFFF);
        end else begin
            e = exp_cmp.pop_front();
            chk("completion", {8'(cls), 8'(core), load}, {8'(e.cls), 8'(e.core), e.load});
        end
        l.cls = cls; l.core = core; l.wen = ramWEN; l.store = ramstore;
        comp_log.push_back(l);
    endtask

    initial forever begin
        cmd_t e;
        @(negedge CLK);
        #1;
        for (int c = 0; c < CPUS; c++) begin
            if (dwait[c] == 1'b0) check_comp(0, c, dload[c*WORD_W +: WORD_W]);
            if (iwait[c] == 1'b0) check_comp(1, c, iload[c*WORD_W +: WORD_W]);
        end
        if (ramREN | ramWEN) begin
            if (exp_cmd.size() == 0) begin
                chk("unexpected_ram_cmd", {ramREN, ramWEN, ramaddr}, 64'h0);
            end else begin
                e = exp_cmd.pop_front();
                chk("ram_cmd", {ramREN, ramWEN, ramaddr}, {e.ren, e.wen, e.addr});
                chk("ram_store", 64'(ramstore), 64'(e.store));
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
        #2;
    endtask

    task automatic chk_defaults(input string name);
        chk({name, "_waits_en"}, {iwait, dwait, ramREN, ramWEN}, {2'b11, 2'b11, 2'b00});
        chk({name, "_ram_bus"}, {ramaddr, ramstore}, 64'h0);
        chk({name, "_loads"}, 64'((|iload) | (|dload)), 64'h0);
    endtask

    task automatic clear_reqs();
        dren_v = '0; dwen_v = '0; iren_v = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst_v = 1'b1;
        cyc(1);
        sample();
        chk_defaults("reset_cycle");
        cyc(1);
        rst_v = 1'b0;
    endtask

    initial begin
        // Reset and idle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("idle", {iwait, dwait, ramREN, ramWEN}, {2'b11, 2'b11, 2'b00});
            cyc(1);
        end

        // Single instruction fetch, ACCESS on the 2nd grant cycle
        do_reset();
        comp_log.delete();
        iaddr_v[0] = 32'h40; iren_v = 2'b01; acc_lat = 2; rs_wait = R_BUSY; load_v = 32'hDEADBEEF;
        sample();
        chk("fetch_idle_cycle", 64'(ramREN), 64'h0);
        cyc(1); sample();
        chk("fetch_grant", {ramREN, ramaddr, iwait}, {1'b1, 32'h40, 2'b11});
        cyc(1); sample();
        chk("fetch_done", {iwait, iload[WORD_W-1:0]}, {2'b10, 32'hDEADBEEF});
        cyc(1); sample();
        chk("fetch_turnaround", {ramREN, iwait}, {1'b0, 2'b11});
        cyc(4);
        chk("fetch_one_pulse", 64'(comp_log.size()), 64'd1);

        // Data round-robin with a writer on core 1
        do_reset();
        comp_log.delete();
        daddr_v[0] = 32'h100; daddr_v[1] = 32'h200;
        dstore_v[0] = 32'hAAAA5555; dstore_v[1] = 32'h12345678;
        dren_v = 2'b11; dwen_v = 2'b10; acc_lat = 1; auto_clr = 1'b0;
        cyc(12);
        clear_reqs(); auto_clr = 1'b1;
        cyc(3);
        chk("rr_count", 64'(comp_log.size() >= 4), 64'd1);
        if (comp_log.size() >= 4)
            for (int k = 0; k < 4; k++)
                chk("rr_order", {8'(comp_log[k].core), 1'(comp_log[k].wen), comp_log[k].store},
                    (k % 2 == 0) ? {8'd0, 1'b0, 32'hAAAA5555} : {8'd1, 1'b1, 32'h12345678});

        // Instruction fairness after DS data grants
        do_reset();
        comp_log.delete();
        daddr_v[0] = 32'h100; iaddr_v[1] = 32'h300;
        dren_v = 2'b01; iren_v = 2'b10; acc_lat = 1; auto_clr = 1'b0;
        cyc(14);
        clear_reqs(); auto_clr = 1'b1;
        cyc(3);
        chk("fair_count", 64'(comp_log.size() >= 6), 64'd1);
        if (comp_log.size() >= 6)
            for (int k = 0; k < 6; k++)
                chk("fair_order", {8'(comp_log[k].cls), 8'(comp_log[k].core)},
                    (k == 4) ? {8'd1, 8'd1} : {8'd0, 8'd0});

        // Withdrawal under BUSY, then ERROR stall
        do_reset();
        daddr_v[0] = 32'h80; daddr_v[1] = 32'h90;
        dren_v = 2'b01; acc_lat = 0; rs_wait = R_BUSY;
        cyc(1); sample();
        chk("wd_grant", {ramREN, ramaddr}, {1'b1, 32'h80});
        cyc(1);
        dren_v = 2'b00;
        sample();
        chk("wd_enables_off", {ramREN, ramWEN, dwait}, {2'b00, 2'b11});
        cyc(1);
        dren_v = 2'b11;
        sample();
        chk("wd_idle", 64'(ramREN), 64'h0);
        cyc(1);
        rs_wait = R_ERROR;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("error_hold", {ramREN, dwait, ramaddr}, {1'b1, 2'b11, 32'h80});
            cyc(1);
        end
        rs_wait = R_ACCESS;
        sample();
        chk("error_then_access", 64'(dwait), 64'(2'b10));
        cyc(1);
        rs_wait = R_BUSY; clear_reqs();
        cyc(3);

        // Reset during a data grant
        do_reset();
        daddr_v[0] = 32'hA0; daddr_v[1] = 32'hB0;
        dren_v = 2'b01; acc_lat = 1; rs_wait = R_BUSY;
        cyc(3);
        dren_v = 2'b11; acc_lat = 0;
        cyc(1); sample();
        chk("rst_pre_owner", {ramREN, ramaddr}, {1'b1, 32'hB0});
        cyc(1);
        rst_v = 1'b1;
        sample();
        chk_defaults("rst_mid_cycle");
        cyc(1);
        rst_v = 1'b0;
        sample();
        chk_defaults("rst_after");
        cyc(1); sample();
        chk("rst_priority_core0", {ramREN, ramaddr}, {1'b1, 32'hA0});
        cyc(1);
        clear_reqs();
        cyc(3);

        // Randomized traffic against the model
        do_reset();
        comp_log.delete();
        mode = 1; auto_clr = 1'b1;
        cyc(3000);
        mode = 0; rs_wait = R_BUSY;
        clear_reqs();
        cyc(5);
        chk("rand_activity", 64'(comp_log.size() > 100), 64'd1);
        chk("cmp_queue_drained", 64'(exp_cmp.size()), 64'd0);
        chk("cmd_queue_drained", 64'(exp_cmd.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
